sbm_digitized_param: RTL and testbench
======================================

// Module: sbm_digitized_param
// PURPOSE
//  Parametrised digit-serial schoolbook multiplier, unsigned C = A*B.
//  Splits B into DIGITS digits of DIGIT_W bits, zero-padding the top digit.
//  Each digit is multiplied with A by shift-add at BPC bits per cycle, then
//  accumulated at offset digit*DIGIT_W.
//  Adds start/busy/done handshake, abort, and optional zero-digit skipping.
//  Sits beside the large-multiplier library cores as the area-optimised option.
// PARAMETERS
//  SIZEA      521  width of operand a
//  SIZEB      521  width of operand b
//  DIGIT_W    81   digit width of b
//  BPC        1    b bits consumed per MUL cycle; DIGIT_W % BPC == 0 (elaboration error otherwise)
//  SKIP_ZERO  0    1: an all-zero digit costs 1 MUL cycle instead of STEPS
//  derived:   DIGITS = ceil(SIZEB/DIGIT_W) (7), STEPS = DIGIT_W/BPC (81)
// PORTS
//  clk    in   1            clock, rising edge
//  rst    in   1            reset, synchronous, active-high
//  start  in   1            request; sampled only in IDLE
//  abort  in   1            cancel the operation in progress
//  a      in   SIZEA        multiplicand, captured on accepted start
//  b      in   SIZEB        multiplier, captured on accepted start
//  busy   out  1            high whenever state != IDLE
//  done   out  1            one-cycle pulse, c valid and updated
//  c      out  SIZEA+SIZEB  product, held until the next done
// BEHAVIOUR
//  Reset: state=IDLE; c=0, done=0, busy=0; internal regs cleared.
//  rst beats abort, and abort beats start.
//  Internal regs:
//   ra, rb: captures of a and b; rb zero-padded to DIGITS*DIGIT_W
//   partial: SIZEA+DIGIT_W bits
//   acc: SIZEA+DIGITS*DIGIT_W bits
//   digit: 0..DIGITS-1; step: 0..STEPS-1
//  IDLE: on start & !abort -> ra=a, rb=b, acc=0, partial=0, digit=0, step=0; go MUL.
//  MUL: each cycle
//   partial += (ra*rb[digit*DIGIT_W+step*BPC +: BPC]) << (step*BPC), step++.
//   After STEPS cycles (step wraps to 0) go ACC.
//   If SKIP_ZERO=1 and the current digit==0 at step 0: no add, go ACC after that 1 cycle.
//  ACC: one cycle
//   acc += partial << (digit*DIGIT_W), partial=0.
//   If digit==DIGITS-1 go DONE, else digit++ and go MUL.
//  DONE: one cycle
//   c = acc[SIZEA+SIZEB-1:0] (exact, no overflow); done=1; go IDLE.
//  done is 0 in every other state.
//  Latency, from the edge sampling start to the edge raising done:
//   DIGITS*(STEPS+1)+1 = 575 at defaults.
//   With SKIP_ZERO, each zero digit costs 2 cycles instead of STEPS+1.
//  A start held high re-launches the cycle after DONE.
//  Back-to-back throughput is one result per latency+1 cycles.
//  start while busy: ignored, with no queueing.
//  Operands are captured, so changes to a and b while busy have no effect.
//  abort in MUL/ACC/DONE: IDLE on the next edge, no done, c unchanged.
//   abort during DONE suppresses that done and c update.
//  rst mid-operation: full reset values next cycle, c cleared.
//  Top digit covers bits [486:520] of b at defaults; padded bits are zero.
//  The product is unaffected by the padding.
// TESTING
//  1. defaults, a=1, b=1
//     -> done exactly 575 cycles after start, c=1, single-cycle pulse.
//  2. a=b=2^521-1
//     -> c=(2^521-1)^2 (bit 0 set, bits 1..521 clear, bits 522..1041 set).
//  3. b=2^520 (top, padded digit only), a=3
//     -> c=3<<520; with SKIP_ZERO=1, latency 6*2+82+1=95.
//  4. start again at cycle 100 of an op with new a, b
//     -> ignored, first result correct, busy never drops early.
//  5. abort at cycle 300 after c holds 7
//     -> busy=0 next cycle, no done, c still 7; new start completes normally.
//  6. rst at cycle 200
//     -> c=0, busy=0, done=0 next cycle.
//     Random SIZEA=13/SIZEB=17/DIGIT_W=6/BPC=2: 1000 ops vs a*b model.

Source files
------------

// File: rtl/sbm_digitized_param_if.sv
// Handshake and operand/result bundle for the digit-serial multiplier.
interface sbm_digitized_param_if #(
  parameter int SIZEA = 521,
  parameter int SIZEB = 521
);
  logic                   start;
  logic                   abort;
  logic [SIZEA-1:0]       a;
  logic [SIZEB-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [SIZEA+SIZEB-1:0] c;

  modport master (output start, abort, a, b, input busy, done, c);
  modport slave  (input start, abort, a, b, output busy, done, c);
endinterface

// File: rtl/sbm_digitized_param.sv
// Digit-serial schoolbook multiplier, unsigned c = a * b.
// b is cut into DIGITS digits of DIGIT_W bits; each digit is multiplied with a
// by shift-add at BPC bits per cycle, then accumulated at digit*DIGIT_W.
//
// state  | meaning
// S_IDLE | waiting for start, operands captured on launch
// S_MUL  | shift-add of one digit into partial, BPC bits per cycle
// S_ACC  | fold partial into acc at the digit offset, advance digit
// S_DONE | publish c and pulse done
module sbm_digitized_param #(
  parameter int SIZEA     = 521,
  parameter int SIZEB     = 521,
  parameter int DIGIT_W   = 81,
  parameter int BPC       = 1,
  parameter int SKIP_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  sbm_digitized_param_if.slave  bus
);

  localparam int DIGITS = (SIZEB + DIGIT_W - 1) / DIGIT_W;
  localparam int STEPS  = DIGIT_W / BPC;
  localparam int RBW    = DIGITS * DIGIT_W;
  localparam int PW     = SIZEA + DIGIT_W;
  localparam int CW     = SIZEA + SIZEB;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW     = (RBW > 1) ? $clog2(RBW) : 1;

  generate
    if (DIGIT_W % BPC != 0) begin : g_bpc_check
      $error("DIGIT_W must be a multiple of BPC");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [SIZEA-1:0] ra;
  logic [RBW-1:0]   rb;
  logic [PW-1:0]    partial;
  // Running sums never exceed the final product, so the accumulator only
  // needs the product width; the bits above CW would always be zero.
  logic [CW-1:0]    acc;
  logic [DW-1:0]    digit;
  logic [STW-1:0]   step;
  logic [CW-1:0]    c_q;
  logic             done_q;

  logic [IW-1:0]      digit_base, bit_idx;
  logic [BPC-1:0]     b_bits;
  logic [DIGIT_W-1:0] b_digit;
  logic [PW-1:0]      addend;
  logic [CW-1:0]      acc_add;
  logic               step_last, digit_last, digit_zero, skip_now, launch;

  // Operand slicing, partial-product term and loop-end conditions.
  always_comb begin
    digit_base = IW'(32'(digit) * DIGIT_W);
    bit_idx    = digit_base + IW'(32'(step) * BPC);
    b_bits     = rb[bit_idx +: BPC];
    b_digit    = rb[digit_base +: DIGIT_W];
    addend     = (PW'(ra) * PW'(b_bits)) << (32'(step) * BPC);
    acc_add    = CW'(partial) << (32'(digit) * DIGIT_W);
    step_last  = (step == STW'(STEPS - 1));
    digit_last = (digit == DW'(DIGITS - 1));
    digit_zero = (b_digit == '0);
    skip_now   = (SKIP_ZERO != 0) && (step == '0) && digit_zero;
    launch     = bus.start && !bus.abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort returns to idle from any active state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (launch) state_nxt = S_MUL;
      S_MUL: begin
        if (bus.abort)                  state_nxt = S_IDLE;
        else if (step_last || skip_now) state_nxt = S_ACC;
      end
      S_ACC: begin
        if (bus.abort)       state_nxt = S_IDLE;
        else if (digit_last) state_nxt = S_DONE;
        else                 state_nxt = S_MUL;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture, shift-add, accumulate and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra      <= '0;
      rb      <= '0;
      partial <= '0;
      acc     <= '0;
      digit   <= '0;
      step    <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            ra      <= bus.a;
            rb      <= RBW'(bus.b);
            acc     <= '0;
            partial <= '0;
            digit   <= '0;
            step    <= '0;
          end
        end
        S_MUL: begin
          if (!bus.abort) begin
            if (!skip_now) partial <= partial + addend;
            step <= (step_last || skip_now) ? '0 : step + STW'(1);
          end
        end
        S_ACC: begin
          if (!bus.abort) begin
            acc     <= acc + acc_add;
            partial <= '0;
            if (!digit_last) digit <= digit + DW'(1);
          end
        end
        S_DONE: begin
          if (!bus.abort) begin
            c_q    <= acc;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.c    = c_q;

endmodule

// File: tb/tb_sbm_digitized_param.sv
// Directed and randomized checks of the digit-serial multiplier at the
// default size, with zero-digit skipping, and at a small odd configuration.
module tb_sbm_digitized_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sbm_digitized_param_if #(.SIZEA(521), .SIZEB(521)) ifd ();
  sbm_digitized_param_if #(.SIZEA(521), .SIZEB(521)) ifs ();
  sbm_digitized_param_if #(.SIZEA(13),  .SIZEB(17))  ifr ();

  sbm_digitized_param u_dut_def (.clk(clk), .rst(rst), .bus(ifd));

  sbm_digitized_param #(.SKIP_ZERO(1)) u_dut_skip (.clk(clk), .rst(rst), .bus(ifs));

  sbm_digitized_param #(
    .SIZEA(13), .SIZEB(17), .DIGIT_W(6), .BPC(2), .SKIP_ZERO(0)
  ) u_dut_rnd (.clk(clk), .rst(rst), .bus(ifr));

  // One operation on the default instance; lat counts edges from the start
  // edge to the edge that raised done (limit value on timeout).
  task automatic op_d(input logic [520:0] av, input logic [520:0] bv, output int lat);
    @(negedge clk); ifd.a = av; ifd.b = bv; ifd.start = 1'b1;
    @(negedge clk); ifd.start = 1'b0; lat = 0;
    while (ifd.done !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic op_s(input logic [520:0] av, input logic [520:0] bv, output int lat);
    @(negedge clk); ifs.a = av; ifs.b = bv; ifs.start = 1'b1;
    @(negedge clk); ifs.start = 1'b0; lat = 0;
    while (ifs.done !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
  endtask

  task automatic op_r(input logic [12:0] av, input logic [16:0] bv, output int lat);
    @(negedge clk); ifr.a = av; ifr.b = bv; ifr.start = 1'b1;
    @(negedge clk); ifr.start = 1'b0; lat = 0;
    while (ifr.done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", ifd.busy); end
    n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", ifd.done); end
    n_checks++; if (ifd.c !== '0) begin n_fail++; $display("FAIL reset_c: got lo=%h expected 0", ifd.c[63:0]); end
    n_checks++; if (ifs.busy !== 1'b0 || ifs.c !== '0) begin n_fail++; $display("FAIL reset_skip: got busy=%b expected 0", ifs.busy); end
    n_checks++; if (ifr.busy !== 1'b0 || ifr.c !== '0) begin n_fail++; $display("FAIL reset_small: got busy=%b c=%0d expected 0 0", ifr.busy, ifr.c); end
    rst = 1'b0;
  endtask

  task automatic test_unit_product();
    int lat;
    op_d(521'd1, 521'd1, lat);
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL unit_latency: got %0d expected 575", lat); end
    n_checks++; if (ifd.c !== 1042'd1) begin n_fail++; $display("FAIL unit_c: got lo=%h expected 1", ifd.c[63:0]); end
    @(negedge clk);
    n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL unit_pulse: got done=%b expected 0", ifd.done); end
    n_checks++; if (ifd.c !== 1042'd1) begin n_fail++; $display("FAIL unit_hold: got lo=%h expected 1", ifd.c[63:0]); end
  endtask

  task automatic test_all_ones();
    int lat;
    logic [520:0]  ones;
    logic [1041:0] e;
    ones = '1;
    e = '0; e[0] = 1'b1;
    for (int i = 522; i < 1042; i++) e[i] = 1'b1;
    op_d(ones, ones, lat);
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL ones_latency: got %0d expected 575", lat); end
    n_checks++; if (ifd.c !== e) begin n_fail++; $display("FAIL ones_c: got hi=%h lo=%h expected hi=%h lo=%h", ifd.c[1041:978], ifd.c[63:0], e[1041:978], e[63:0]); end
    op_s(ones, ones, lat);
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL ones_skip_latency: got %0d expected 575", lat); end
    n_checks++; if (ifs.c !== e) begin n_fail++; $display("FAIL ones_skip_c: got hi=%h lo=%h expected hi=%h lo=%h", ifs.c[1041:978], ifs.c[63:0], e[1041:978], e[63:0]); end
  endtask

  task automatic test_top_digit();
    int lat;
    logic [520:0]  bt;
    logic [1041:0] e;
    bt = '0; bt[520] = 1'b1;
    e = '0; e[521:520] = 2'b11;
    op_d(521'd3, bt, lat);
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL top_latency: got %0d expected 575", lat); end
    n_checks++; if (ifd.c !== e) begin n_fail++; $display("FAIL top_c: got hi=%h lo=%h expected hi=%h lo=%h", ifd.c[1041:978], ifd.c[63:0], e[1041:978], e[63:0]); end
    op_s(521'd3, bt, lat);
    n_checks++; if (lat !== 95) begin n_fail++; $display("FAIL top_skip_latency: got %0d expected 95", lat); end
    n_checks++; if (ifs.c !== e) begin n_fail++; $display("FAIL top_skip_c: got hi=%h lo=%h expected hi=%h lo=%h", ifs.c[1041:978], ifs.c[63:0], e[1041:978], e[63:0]); end
    op_s(521'd5, 521'd0, lat);
    n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL zero_skip_latency: got %0d expected 15", lat); end
    n_checks++; if (ifs.c !== '0) begin n_fail++; $display("FAIL zero_skip_c: got lo=%h expected 0", ifs.c[63:0]); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    bit busy_bad;
    @(negedge clk); ifd.a = 521'd12345; ifd.b = 521'd678; ifd.start = 1'b1;
    @(negedge clk); ifd.start = 1'b0; lat = 0; busy_bad = 1'b0;
    while (ifd.done !== 1'b1 && lat < 2000) begin
      if (lat == 100) begin ifd.a = 521'd999; ifd.b = 521'd777; ifd.start = 1'b1; end
      else ifd.start = 1'b0;
      @(negedge clk); lat++;
      if (ifd.done !== 1'b1 && ifd.busy !== 1'b1) busy_bad = 1'b1;
    end
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 575", lat); end
    n_checks++; if (ifd.c !== 1042'd8369910) begin n_fail++; $display("FAIL busy_start_c: got %0d expected 8369910", ifd.c[63:0]); end
    n_checks++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL busy_start_busy: got early drop=%b expected 0", busy_bad); end
    @(negedge clk);
    n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_queue: got busy=%b expected 0", ifd.busy); end
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    op_d(521'd7, 521'd1, lat);
    n_checks++; if (ifd.c !== 1042'd7) begin n_fail++; $display("FAIL abort_pre_c: got %0d expected 7", ifd.c[63:0]); end
    @(negedge clk); ifd.a = 521'd5; ifd.b = 521'd5; ifd.start = 1'b1;
    @(negedge clk); ifd.start = 1'b0;
    repeat (299) @(negedge clk);
    ifd.abort = 1'b1;
    @(negedge clk); ifd.abort = 1'b0;
    n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", ifd.busy); end
    n_checks++; if (ifd.c !== 1042'd7) begin n_fail++; $display("FAIL abort_c: got %0d expected 7", ifd.c[63:0]); end
    seen = 1'b0;
    repeat (600) begin @(negedge clk); if (ifd.done !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got done seen=%b expected 0", seen); end
    op_d(521'd3, 521'd9, lat);
    n_checks++; if (lat !== 575) begin n_fail++; $display("FAIL abort_restart_latency: got %0d expected 575", lat); end
    n_checks++; if (ifd.c !== 1042'd27) begin n_fail++; $display("FAIL abort_restart_c: got %0d expected 27", ifd.c[63:0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ifd.a = 521'd2; ifd.b = 521'd2; ifd.start = 1'b1;
    @(negedge clk); ifd.start = 1'b0;
    repeat (199) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (ifd.c !== '0) begin n_fail++; $display("FAIL rst_mid_c: got %0d expected 0", ifd.c[63:0]); end
    n_checks++; if (ifd.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", ifd.busy); end
    n_checks++; if (ifd.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", ifd.done); end
  endtask

  task automatic test_back_to_back();
    int n, gap;
    @(negedge clk); ifr.a = 13'd5; ifr.b = 17'd7; ifr.start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (ifr.done !== 1'b1 && n < 100);
    gap = 0;
    do begin @(negedge clk); gap++; end while (ifr.done !== 1'b1 && gap < 100);
    ifr.start = 1'b0;
    n_checks++; if (gap !== 14) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 14", gap); end
    n_checks++; if (ifr.c !== 30'd35) begin n_fail++; $display("FAIL b2b_c: got %0d expected 35", ifr.c); end
    repeat (2) @(negedge clk);
    n_checks++; if (ifr.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: got busy=%b expected 0", ifr.busy); end
  endtask

  task automatic test_abort_in_done();
    int lat;
    op_r(13'd11, 17'd13, lat);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL small_latency: got %0d expected 13", lat); end
    n_checks++; if (ifr.c !== 30'd143) begin n_fail++; $display("FAIL small_c: got %0d expected 143", ifr.c); end
    @(negedge clk); ifr.a = 13'd3; ifr.b = 17'd3; ifr.start = 1'b1;
    @(negedge clk); ifr.start = 1'b0;
    repeat (12) @(negedge clk);
    ifr.abort = 1'b1;
    @(negedge clk); ifr.abort = 1'b0;
    n_checks++; if (ifr.done !== 1'b0) begin n_fail++; $display("FAIL done_abort_done: got %b expected 0", ifr.done); end
    n_checks++; if (ifr.c !== 30'd143 || ifr.busy !== 1'b0) begin n_fail++; $display("FAIL done_abort_c: got c=%0d busy=%b expected 143 0", ifr.c, ifr.busy); end
  endtask

  task automatic test_random();
    int lat;
    logic [12:0] av;
    logic [16:0] bv;
    logic [29:0] e;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)      begin av = '1; bv = '1; end
      else if (i == 1) begin av = '1; bv = '0; end
      else begin
        av = 13'($urandom_range(0, 8191));
        bv = 17'($urandom_range(0, 131071));
      end
      e = 30'(av) * 30'(bv);
      op_r(av, bv, lat);
      n_checks++;
      if (ifr.c !== e || lat !== 13) begin
        n_fail++;
        $display("FAIL random_%0d: a=%0d b=%0d got c=%0d lat=%0d expected c=%0d lat=13", i, av, bv, ifr.c, lat, e);
      end
    end
  endtask

  initial begin
    ifd.start = 1'b0; ifd.abort = 1'b0; ifd.a = '0; ifd.b = '0;
    ifs.start = 1'b0; ifs.abort = 1'b0; ifs.a = '0; ifs.b = '0;
    ifr.start = 1'b0; ifr.abort = 1'b0; ifr.a = '0; ifr.b = '0;
    test_reset();
    test_unit_product();
    test_all_ones();
    test_top_digit();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_abort_in_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
